// File: rtl/instruction_memory_pkg.sv
// Shared definitions for the execute/commit block: default data width,
// opcode type and opcode encodings.
package instruction_memory_pkg;

  localparam int DATA_WIDTH = 8;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_ADD = 3'b000;
  localparam opcode_t OP_SUB = 3'b001;
  localparam opcode_t OP_AND = 3'b010;
  localparam opcode_t OP_OR  = 3'b011;
  localparam opcode_t OP_XOR = 3'b100;
  localparam opcode_t OP_MUL = 3'b101;
  localparam opcode_t OP_DIV = 3'b110;
  localparam opcode_t OP_CMP = 3'b111;

endpackage

// File: rtl/instruction_memory_alu_core.sv
// Purely combinational ALU: a, b, opcode -> alu_out, carry_out.
// Build option: define INSTR_MEM_MULDIV_EN to include the multiplier and
// divider; without it MUL/DIV return zero with a clear flag.
module alu_core
  import instruction_memory_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_t          opcode,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Extended sum/difference; the top bit of diff is the borrow (a < b).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

`ifdef INSTR_MEM_MULDIV_EN
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;

  // Full-width product so the high half can flag overflow.
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  // Guard the divisor so the divider never sees zero; the zero case is
  // overridden in the opcode mux anyway.
  assign quot = (b == '0) ? '0 : (a / b);
`endif

  // Opcode mux; evaluated every cycle independent of commit.
  always_comb begin
    alu_out   = '0;
    carry_out = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_out   = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
      end
      OP_SUB: begin
        alu_out   = diff[WIDTH-1:0];
        carry_out = diff[WIDTH];
      end
      OP_AND: alu_out = a & b;
      OP_OR:  alu_out = a | b;
      OP_XOR: alu_out = a ^ b;
`ifdef INSTR_MEM_MULDIV_EN
      OP_MUL: begin
        alu_out   = prod[WIDTH-1:0];
        carry_out = |prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        if (b == '0) begin
          alu_out   = '1;
          carry_out = 1'b1;
        end else begin
          alu_out   = quot;
        end
      end
`else
      OP_MUL: alu_out = '0;
      OP_DIV: alu_out = '0;
`endif
      OP_CMP: begin
        alu_out   = (a > b) ? WIDTH'(1) : '0;
        carry_out = (a == b);
      end
      default: begin
        alu_out   = '0;
        carry_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instruction_memory.sv
// Single-cycle execute/commit block: live ALU result plus registered commit
// of result and opcode when save is high.
// Build option: INSTR_MEM_MULDIV_EN enables MUL/DIV inside alu_core.
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_t          opcode,
  input  logic             save,
  output opcode_t          alu_sel,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic [WIDTH-1:0] data_out
);

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .alu_out   (alu_out),
    .carry_out (carry_out)
  );

  // Commit registers; an unknown save falls into the hold branch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      alu_sel  <= OP_ADD;
    end else if (save) begin
      data_out <= alu_out;
      alu_sel  <= opcode;
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Directed, table-driven bench for instruction_memory. MUL/DIV expectations
// follow the INSTR_MEM_MULDIV_EN build option.
module tb_instruction_memory;
  import instruction_memory_pkg::*;

  typedef struct {
    opcode_t    op;
    logic [7:0] a;
    logic [7:0] b;
    logic       save;
    logic [7:0] exp_alu;
    logic       exp_carry;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  opcode_t    opcode;
  logic       save;
  opcode_t    alu_sel;
  logic [7:0] alu_out;
  logic       carry_out;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_data;
  opcode_t    exp_sel;

  vec_t vecs [17];

  instruction_memory #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .save      (save),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(opcode_t op, logic [7:0] va, logic [7:0] vb, logic s,
                              logic [7:0] ea, logic ec);
    vec_t v;
    v.op = op; v.a = va; v.b = vb; v.save = s; v.exp_alu = ea; v.exp_carry = ec;
    return v;
  endfunction

  // Drive one vector just after an edge, check the live result, then check
  // the registers one edge later against the bench's own commit model.
  task automatic apply(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    opcode = v.op; a = v.a; b = v.b; save = v.save;
    #1;
    chk({tag, "_alu_out"}, alu_out, v.exp_alu);
    chk({tag, "_carry"}, {7'd0, carry_out}, {7'd0, v.exp_carry});
    @(posedge clk); #1;
    if (v.save) begin
      exp_data = v.exp_alu;
      exp_sel  = v.op;
    end
    chk({tag, "_data_out"}, data_out, exp_data);
    chk({tag, "_alu_sel"}, {5'd0, alu_sel}, {5'd0, exp_sel});
  endtask

  initial begin
    vecs[0]  = mk(OP_ADD, 8'h05, 8'h03, 1'b1, 8'h08, 1'b0);
    vecs[1]  = mk(OP_SUB, 8'hCC, 8'hAA, 1'b1, 8'h22, 1'b0);
    vecs[2]  = mk(OP_SUB, 8'h03, 8'h05, 1'b1, 8'hFE, 1'b1);
    vecs[3]  = mk(OP_ADD, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1);
    vecs[4]  = mk(OP_AND, 8'h05, 8'h03, 1'b1, 8'h01, 1'b0);
    vecs[5]  = mk(OP_OR,  8'hCC, 8'hAA, 1'b1, 8'hEE, 1'b0);
    vecs[6]  = mk(OP_XOR, 8'h05, 8'h03, 1'b1, 8'h06, 1'b0);
    vecs[7]  = mk(OP_CMP, 8'hCC, 8'hAA, 1'b1, 8'h01, 1'b0);
    vecs[8]  = mk(OP_CMP, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1);
`ifdef INSTR_MEM_MULDIV_EN
    vecs[9]  = mk(OP_MUL, 8'hCC, 8'hAA, 1'b1, 8'h78, 1'b1);
    vecs[10] = mk(OP_DIV, 8'h05, 8'h03, 1'b1, 8'h01, 1'b0);
    vecs[11] = mk(OP_DIV, 8'h05, 8'h00, 1'b1, 8'hFF, 1'b1);
`else
    vecs[9]  = mk(OP_MUL, 8'hCC, 8'hAA, 1'b1, 8'h00, 1'b0);
    vecs[10] = mk(OP_DIV, 8'h05, 8'h03, 1'b1, 8'h00, 1'b0);
    vecs[11] = mk(OP_DIV, 8'h05, 8'h00, 1'b1, 8'h00, 1'b0);
`endif
    vecs[12] = mk(OP_ADD, 8'h05, 8'h03, 1'b1, 8'h08, 1'b0);
    vecs[13] = mk(OP_XOR, 8'h05, 8'h03, 1'b0, 8'h06, 1'b0);
    vecs[14] = mk(OP_CMP, 8'h02, 8'h01, 1'b0, 8'h01, 1'b0);
    vecs[15] = mk(OP_ADD, 8'h10, 8'h20, 1'b1, 8'h30, 1'b0);
    vecs[16] = mk(OP_OR,  8'hCC, 8'hAA, 1'b1, 8'hEE, 1'b0);

    // Reset held low with save high across several edges.
    reset = 1'b0; save = 1'b1; opcode = OP_OR; a = 8'hCC; b = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_alu_sel", {5'd0, alu_sel}, 8'h00);
    reset = 1'b1;
    exp_data = 8'h00;
    exp_sel  = OP_ADD;

    foreach (vecs[i]) apply(i, vecs[i]);

    // Last commit left OR/EE in the registers; drop reset between edges.
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_data_out", data_out, 8'h00);
    chk("async_rst_alu_sel", {5'd0, alu_sel}, 8'h00);

    // Edges with save high while reset is low must not commit.
    save = 1'b1; opcode = OP_SUB; a = 8'hCC; b = 8'hAA;
    @(posedge clk); #1;
    chk("rst_save_ignored", data_out, 8'h00);
    #2;
    reset = 1'b1;

    // Unknown save holds the registers.
    save = 1'bx; opcode = OP_ADD; a = 8'h05; b = 8'h03;
    @(posedge clk); #1;
    chk("x_save_hold", data_out, 8'h00);

    // First real commit after release.
    save = 1'b1; opcode = OP_XOR;
    @(posedge clk); #1;
    chk("post_rst_commit_data", data_out, 8'h06);
    chk("post_rst_commit_sel", {5'd0, alu_sel}, {5'd0, OP_XOR});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete (t=%0t)", $time);
    $fatal(1);
  end

endmodule
